// File: rtl/axi4_lite_slave_write_responder_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) shared by the write responder
// and whatever master drives it.
interface axi4_lite_slave_write_responder_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
) ();
   logic [ADDRESS_WIDTH-1:0]  awaddr;
   logic [2:0]                awprot;
   logic                      awvalid;
   logic                      awready;
   logic [DATA_WIDTH-1:0]     wdata;
   logic [DATA_WIDTH/8-1:0]   wstrb;
   logic                      wvalid;
   logic                      wready;
   logic [1:0]                bresp;
   logic                      bvalid;
   logic                      bready;

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output awready, wready, bresp, bvalid
   );

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/axi4_lite_slave_write_responder.sv
// AXI4-Lite slave write endpoint: programmable ready delay, independent AW/W
// capture, byte-strobed commit into a word register file, OKAY/SLVERR/DECERR.
// Optional macro AXI4_LITE_WRITE_PROT_CHECK_EN: non-secure (awprot[1]=1)
// in-range aligned writes answer SLVERR and do not write.
module axi4_lite_slave_write_responder #(
   parameter int                     ADDRESS_WIDTH = 32,
   parameter int                     DATA_WIDTH    = 32,
   parameter int                     DELAY_WIDTH   = 4,
   parameter int                     NUM_REGS      = 16,
   parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR   = '0,
   localparam int                    IDX_W         = $clog2(NUM_REGS)
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   axi4_lite_slave_write_responder_if.slave bus,
   input  logic [DELAY_WIDTH-1:0] cfg_delay_for_ready,
   input  logic [IDX_W-1:0]       peek_index,
   output logic [DATA_WIDTH-1:0]  peek_data
);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LSB    = $clog2(STRB_W);
   localparam logic [ADDRESS_WIDTH:0] BASE_EXT = {1'b0, BASE_ADDR};
   localparam logic [ADDRESS_WIDTH:0] SPAN     = (ADDRESS_WIDTH+1)'(NUM_REGS * STRB_W);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCEPT, S_RESP} state_t;

   state_t                   state_q, state_d;
   logic [DELAY_WIDTH-1:0]   cnt_q, cnt_d;
   logic                     aw_got_q, aw_got_d, w_got_q, w_got_d;
   logic [ADDRESS_WIDTH-1:0] awaddr_q, awaddr_d;
   logic                     prot1_q, prot1_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic [STRB_W-1:0]        wstrb_q, wstrb_d;
   logic                     awready_q, awready_d, wready_q, wready_d;
   logic                     bvalid_q, bvalid_d;
   logic [1:0]               bresp_q, bresp_d;
   logic                     wr_en;
   logic [IDX_W-1:0]         wr_idx;
   logic [ADDRESS_WIDTH:0]   off;
   logic [1:0]               resp_c;
   logic [DATA_WIDTH-1:0]    regs_q [NUM_REGS];
   logic                     aw_hs, w_hs;

   // Out-of-window beats DECERR first; misaligned or (optionally) non-secure SLVERR.
   function automatic logic [1:0] decode_resp(input logic [ADDRESS_WIDTH-1:0] a,
                                              input logic nonsecure);
      logic [ADDRESS_WIDTH:0] ax;
      ax = {1'b0, a};
      if (ax < BASE_EXT || ax >= BASE_EXT + SPAN) return RESP_DECERR;
      if (a[LSB-1:0] != '0)                       return RESP_SLVERR;
      if (nonsecure)                              return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

   assign aw_hs = bus.awvalid & awready_q;
   assign w_hs  = bus.wvalid & wready_q;

   assign bus.awready = awready_q;
   assign bus.wready  = wready_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.bresp   = bresp_q;
   assign peek_data   = regs_q[peek_index];

   // Next-state, payload capture, decode and registered-output precompute.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      aw_got_d = aw_got_q;
      w_got_d  = w_got_q;
      awaddr_d = awaddr_q;
      prot1_d  = prot1_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      bresp_d  = bresp_q;
      bvalid_d = bvalid_q;
      wr_en    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.awvalid | bus.wvalid) begin
               if (cfg_delay_for_ready == '0) begin
                  state_d = S_ACCEPT;
               end else begin
                  cnt_d   = cfg_delay_for_ready - DELAY_WIDTH'(1);
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) state_d = S_ACCEPT;
            else             cnt_d   = cnt_q - DELAY_WIDTH'(1);
         end
         S_ACCEPT: begin
            if (aw_hs) begin
               aw_got_d = 1'b1;
               awaddr_d = bus.awaddr;
`ifdef AXI4_LITE_WRITE_PROT_CHECK_EN
               prot1_d  = bus.awprot[1];
`endif
            end
            if (w_hs) begin
               w_got_d = 1'b1;
               wdata_d = bus.wdata;
               wstrb_d = bus.wstrb;
            end
            // Same-cycle completion uses the just-captured payload via the _d copies.
            if (aw_got_d && w_got_d) begin
               bresp_d  = resp_c;
               bvalid_d = 1'b1;
               wr_en    = (resp_c == RESP_OKAY);
               state_d  = S_RESP;
            end
         end
         S_RESP: begin
            if (bus.bready) begin
               bvalid_d = 1'b0;
               aw_got_d = 1'b0;
               w_got_d  = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      off       = {1'b0, awaddr_d} - BASE_EXT;
      wr_idx    = IDX_W'(off >> LSB);
      resp_c    = decode_resp(awaddr_d, prot1_d);
      awready_d = (state_d == S_ACCEPT) && !aw_got_d;
      wready_d  = (state_d == S_ACCEPT) && !w_got_d;
   end

   // Control state, captured payload and registered handshake outputs.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         awaddr_q  <= '0;
         prot1_q   <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         aw_got_q  <= aw_got_d;
         w_got_q   <= w_got_d;
         awaddr_q  <= awaddr_d;
         prot1_q   <= prot1_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   // Register file: byte-strobed commit on an OKAY write.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         for (int b = 0; b < STRB_W; b++)
            if (wstrb_d[b]) regs_q[wr_idx][8*b +: 8] <= wdata_d[8*b +: 8];
      end
   end
endmodule

// File: tb/tb_axi4_lite_slave_write_responder.sv
// Self-checking bench for axi4_lite_slave_write_responder (default params).
// Directed table, reset sequences, then random traffic against a word-array model.
module tb_axi4_lite_slave_write_responder;
`ifdef AXI4_LITE_WRITE_PROT_CHECK_EN
   localparam bit PROT_EN = 1'b1;
`else
   localparam bit PROT_EN = 1'b0;
`endif

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [3:0]  cfg;
   logic [3:0]  peek_index;
   logic [31:0] peek_data;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] mdl [16];

   axi4_lite_slave_write_responder_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axi4_lite_slave_write_responder dut (
      .aclk                (aclk),
      .aresetn             (aresetn),
      .bus                 (bus),
      .cfg_delay_for_ready (cfg),
      .peek_index          (peek_index),
      .peek_data           (peek_data)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [2:0]  prot;
      logic [3:0]  cfg;
      int          da, dw, db;
      bit          stray;
      logic [1:0]  eresp;
      int          pidx;
      logic [31:0] epeek;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic peek_chk(input int idx, input logic [31:0] exp, input string nm);
      peek_index = 4'(idx);
      #1;
      chk(nm, peek_data, exp);
   endtask

   task automatic zero_inputs();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      bus.awaddr = '0; bus.wdata = '0; bus.wstrb = '0; bus.awprot = '0;
   endtask

   // Response rules straight from the address map.
   function automatic logic [1:0] mresp(input logic [31:0] a, input logic [2:0] p);
      if (a >= 32'd64)         return 2'b11;
      if (a % 4 != 0)          return 2'b10;
      if (PROT_EN && p[1])     return 2'b10;
      return 2'b00;
   endfunction

   function automatic void mwrite(input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] s, input logic [2:0] p);
      if (mresp(a, p) == 2'b00)
         for (int b = 0; b < 4; b++)
            if (s[b]) mdl[a/4][8*b +: 8] = d[8*b +: 8];
   endfunction

   // One full write; cycle 0 is the first cycle the FSM is idle. Handshake and
   // response cycles are checked against: readies open at min(da,dw)+cfg+1.
   task automatic run_txn(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [2:0] prot,
                          input logic [3:0] c, input int da, input int dw,
                          input int db, input bit stray, output logic [1:0] resp);
      int  hs_aw = -1, hs_w = -1, bv = -1, bcnt = 0;
      int  rs, e_aw, e_w;
      bit  aw_done = 0, w_done = 0, done = 0, bad_stable = 0, bad_rdy = 0;
      bit  av;
      rs   = ((da < dw) ? da : dw) + int'(c) + 1;
      e_aw = (da > rs) ? da : rs;
      e_w  = (dw > rs) ? dw : rs;
      resp = 2'bxx;
      for (int k = 0; k < 64 && !done; k++) begin
         @(posedge aclk); #1;
         if (k == 0) begin
            chk("idle_bvalid", 32'(bus.bvalid), 32'd0);
            chk("idle_ready", 32'({bus.awready, bus.wready}), 32'd0);
         end
         cfg = c;
         bus.awaddr = addr; bus.awprot = prot;
         bus.wdata = data; bus.wstrb = strb;
         av = (k >= da) && !aw_done;
         bus.awvalid = av;
         bus.wvalid  = (k >= dw) && !w_done;
         bus.bready  = 1'b0;
         if (stray && aw_done && w_done) begin
            bus.awvalid = 1'b1;
            bus.awaddr  = addr ^ 32'h4;
         end
         if (bus.bvalid) begin
            if (bv < 0) begin bv = k; resp = bus.bresp; end
            else if (bus.bresp !== resp) bad_stable = 1;
            if (bus.awready || bus.wready) bad_rdy = 1;
            if (bcnt == db) begin bus.bready = 1'b1; done = 1; end
            bcnt++;
         end
         if (av && bus.awready) begin aw_done = 1; hs_aw = k; end
         if (bus.wvalid && bus.wready) begin w_done = 1; hs_w = k; end
      end
      chk("b_handshake_done", 32'(done), 32'd1);
      chk("aw_hs_cycle", 32'(hs_aw), 32'(e_aw));
      chk("w_hs_cycle", 32'(hs_w), 32'(e_w));
      chk("bvalid_cycle", 32'(bv), 32'(((e_aw > e_w) ? e_aw : e_w) + 1));
      chk("bresp_stable", 32'(bad_stable), 32'd0);
      chk("ready_low_in_resp", 32'(bad_rdy), 32'd0);
      @(posedge aclk); #1;
      zero_inputs();
      chk("bvalid_drop", 32'(bus.bvalid), 32'd0);
   endtask

   initial begin
      logic [1:0]  r;
      logic [31:0] a, d;
      logic [3:0]  s;
      logic [2:0]  p;
      int          idx;

      tbl[0]  = '{32'h8,  32'hDEADBEEF, 4'hF, 3'd0, 4'd0, 0, 0, 0, 1'b0, 2'b00, 2, 32'hDEADBEEF};
      tbl[1]  = '{32'h40, 32'h12345678, 4'hF, 3'd0, 4'd0, 0, 0, 0, 1'b0, 2'b11, 0, 32'h0};
      tbl[2]  = '{32'h6,  32'h12345678, 4'hF, 3'd0, 4'd0, 0, 0, 0, 1'b0, 2'b10, 1, 32'h0};
      tbl[3]  = '{32'h4,  32'h11223344, 4'hF, 3'd0, 4'd0, 1, 0, 0, 1'b0, 2'b00, 1, 32'h11223344};
      tbl[4]  = '{32'h4,  32'hAABBCCDD, 4'h5, 3'd0, 4'd0, 0, 2, 1, 1'b0, 2'b00, 1, 32'h11BB33DD};
      tbl[5]  = '{32'hC,  32'hFFFFFFFF, 4'h0, 3'd0, 4'd0, 0, 0, 0, 1'b0, 2'b00, 3, 32'h0};
      tbl[6]  = '{32'h10, 32'hCAFEF00D, 4'hF, 3'd0, 4'd3, 0, 5, 0, 1'b0, 2'b00, 4, 32'hCAFEF00D};
      tbl[7]  = '{32'h14, 32'h01020304, 4'hF, 3'd0, 4'd0, 0, 0, 4, 1'b1, 2'b00, 5, 32'h01020304};
      tbl[8]  = '{32'h0,  32'h55AA55AA, 4'hF, 3'b010, 4'd0, 0, 0, 0, 1'b0,
                  PROT_EN ? 2'b10 : 2'b00, 0, PROT_EN ? 32'h0 : 32'h55AA55AA};
      tbl[9]  = '{32'h3C, 32'h87654321, 4'hF, 3'd0, 4'd1, 2, 0, 0, 1'b0, 2'b00, 15, 32'h87654321};
      tbl[10] = '{32'hFFFFFFFC, 32'h0BADF00D, 4'hF, 3'd0, 4'd2, 0, 0, 0, 1'b0, 2'b11, 15, 32'h87654321};

      // Power-on reset.
      aresetn = 1'b0; cfg = '0; peek_index = '0;
      zero_inputs();
      for (int i = 0; i < 16; i++) mdl[i] = '0;
      #3;
      chk("rst_awready", 32'(bus.awready), 32'd0);
      chk("rst_wready", 32'(bus.wready), 32'd0);
      chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
      chk("rst_bresp", 32'(bus.bresp), 32'd0);
      peek_chk(7, 32'h0, "rst_reg7");
      @(posedge aclk); #3; aresetn = 1'b1;

      // Directed table.
      for (int i = 0; i < 11; i++) begin
         run_txn(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].prot, tbl[i].cfg,
                 tbl[i].da, tbl[i].dw, tbl[i].db, tbl[i].stray, r);
         mwrite(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].prot);
         chk($sformatf("tbl%0d_bresp", i), 32'(r), 32'(tbl[i].eresp));
         peek_chk(tbl[i].pidx, tbl[i].epeek, $sformatf("tbl%0d_peek", i));
      end

      // Reset while in WAIT: everything clears, registers included.
      @(posedge aclk); #1;
      cfg = 4'd6; bus.awaddr = 32'h8; bus.wdata = 32'h1; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      repeat (2) @(posedge aclk);
      #3; aresetn = 1'b0; #1;
      chk("wait_rst_awready", 32'(bus.awready), 32'd0);
      chk("wait_rst_wready", 32'(bus.wready), 32'd0);
      chk("wait_rst_bvalid", 32'(bus.bvalid), 32'd0);
      peek_chk(2, 32'h0, "wait_rst_reg2");
      peek_chk(1, 32'h0, "wait_rst_reg1");
      zero_inputs();
      for (int i = 0; i < 16; i++) mdl[i] = '0;
      @(posedge aclk); #3; aresetn = 1'b1;

      // Reset while in RESP with bready low: response dropped, write undone.
      @(posedge aclk); #1;
      cfg = 4'd0; bus.awaddr = 32'h8; bus.wdata = 32'h600DCAFE; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      @(posedge aclk); #1;
      chk("resp_seq_awready", 32'(bus.awready), 32'd1);
      chk("resp_seq_wready", 32'(bus.wready), 32'd1);
      @(posedge aclk); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      chk("resp_seq_bvalid", 32'(bus.bvalid), 32'd1);
      chk("resp_seq_ready_drop", 32'({bus.awready, bus.wready}), 32'd0);
      peek_chk(2, 32'h600DCAFE, "resp_seq_commit");
      repeat (2) @(posedge aclk);
      #2; aresetn = 1'b0; #1;
      chk("resp_rst_bvalid", 32'(bus.bvalid), 32'd0);
      chk("resp_rst_bresp", 32'(bus.bresp), 32'd0);
      peek_chk(2, 32'h0, "resp_rst_reg2");
      zero_inputs();
      @(posedge aclk); #3; aresetn = 1'b1;

      // Random traffic against the model.
      for (int n = 0; n < 60; n++) begin
         a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         p = 3'($urandom_range(0, 7));
         run_txn(a, d, s, p, 4'($urandom_range(0, 3)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, r);
         chk($sformatf("rnd%0d_bresp a=%0h", n, a), 32'(r), 32'(mresp(a, p)));
         mwrite(a, d, s, p);
         idx = (a < 32'd64) ? int'(a[5:2]) : $urandom_range(0, 15);
         peek_chk(idx, mdl[idx], $sformatf("rnd%0d_peek%0d", n, idx));
      end
      for (int i = 0; i < 16; i++) peek_chk(i, mdl[i], $sformatf("final_reg%0d", i));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axi4_lite_slave_write_responder.md
Name: axi4_lite_slave_write_responder

Overview:
- RTL slave-side AXI4-Lite write-channel endpoint; consumes AW/W beats from the master BFM/interconnect and produces the B response.
- Accepts address and data independently, then commits the data into a local word-addressed register file with byte strobes.
- Inserts a programmable ready delay that mirrors delayForReadyWriteCfgValue from the shared globals package.
- Returns WRITE_OKAY, WRITE_SLVERR or WRITE_DECERR encodings on bresp.

Parameters:
ADDRESS_WIDTH, 32, awaddr width
DATA_WIDTH, 32, wdata width; must be 32 or 64
DELAY_WIDTH, 4, width of ready-delay config
NUM_REGS, 16, register file depth in words; power of two, 2..256
BASE_ADDR, 0, byte address of register 0; aligned to NUM_REGS*DATA_WIDTH/8

Ports:
aclk  input  1  clock
aresetn  input  1  asynchronous active-low reset
awaddr  input  ADDRESS_WIDTH  write address
awprot  input  3  protection (awprotEnum encoding)
awvalid  input  1  address valid
awready  output  1  address ready
wdata  input  DATA_WIDTH  write data
wstrb  input  DATA_WIDTH/8  byte strobes
wvalid  input  1  data valid
wready  output  1  data ready
bresp  output  2  response (brespEnum encoding)
bvalid  output  1  response valid
bready  input  1  response ready
cfg_delay_for_ready  input  DELAY_WIDTH  ready delay in cycles
peek_index  input  log2(NUM_REGS)  register-file read index
peek_data  output  DATA_WIDTH  combinational read of reg[peek_index]

Behaviour:
- Reset: aresetn low clears asynchronously, regardless of in-flight state. Outputs: awready=0, wready=0, bvalid=0, bresp=2'b00. FSM returns to IDLE, capture flags clear, all registers clear to 0. An in-flight transaction is dropped without a response.
- IDLE: awready=wready=0. On a cycle with awvalid|wvalid:
  - cfg==0 -> go to ACCEPT.
  - otherwise load cnt=cfg-1 -> go to WAIT.
  - cfg is sampled only in that cycle.
- WAIT: ready outputs stay 0. cnt decrements each cycle; when cnt==0, go to ACCEPT. The first ready rises cfg+1 cycles after the first valid.
- ACCEPT:
  - awready = !aw_got; wready = !w_got; both are registered outputs.
  - Handshake on each channel captures that channel's payload and sets its got flag.
  - Both channels in the same cycle is legal and captures both.
  - When both flags are set (including same-cycle completion): perform decode/commit, go to RESP. Both readies drop the next cycle.
- Decode uses the captured awaddr:
  - addr < BASE_ADDR or addr >= BASE_ADDR+NUM_REGS*DATA_WIDTH/8 -> DECERR (2'b11), no write.
  - Otherwise, low log2(DATA_WIDTH/8) address bits nonzero -> SLVERR (2'b10), no write.
  - Otherwise OKAY (2'b00). Write reg[idx] byte-wise where wstrb bit is set. wstrb==0 is OKAY with no change.
  - DECERR has priority over SLVERR.
- RESP: bvalid=1 with stable bresp. On bready: clear got flags, go to IDLE; bvalid drops next cycle.
  - awvalid/wvalid seen in RESP are not accepted; a new transaction starts in IDLE on the cycle after the B handshake.
- Latency (cfg=0, both valids in cycle 0, bready high):
  - handshakes in cycle 1;
  - register updated and bvalid=1 in cycle 2;
  - back in IDLE in cycle 3.
- Master holds payload while valid is high; no combinational paths from inputs to awready/wready/bvalid.
- peek_data updates the cycle after the commit edge.

Optional Feature:
AXI4_LITE_WRITE_PROT_CHECK_EN:
- Defined: an in-range, aligned write with awprot[1]=1 (non-secure) gets SLVERR and no write. DECERR still wins.
- Undefined: awprot is ignored; the decode rules above apply unchanged.

Test Plan:
- cfg=0, addr 0x8, data 0xDEADBEEF, wstrb 0xF, bready=1 -> awready/wready in cycle 1, bvalid cycle 2 with bresp=00, peek_index=2 gives 0xDEADBEEF.
- cfg=3, awvalid at cycle 0, wvalid at cycle 5 -> awready high cycle 4; wready held until the W handshake; bvalid one cycle after the W handshake; a 3-cycle ready delay measured from the first valid.
- Addr 0x40 (NUM_REGS=16) -> DECERR 11, no register changes. Addr 0x6 -> SLVERR 10, no change.
- reg1=0x11223344, write wstrb=0x5 data 0xAABBCCDD -> reg1=0x11BB33DD, OKAY.
- bready held low 4 cycles -> bvalid/bresp stable; new awvalid ignored until after the B handshake.
- aresetn pulsed low during WAIT and during RESP -> awready/wready/bvalid 0 immediately, registers 0, FSM IDLE.
- Macro defined: awprot=3'b010, addr 0x0 -> SLVERR, no write. Macro undefined: same stimulus -> OKAY and write.
